// File: rtl/gpr_pkg.sv
// gpr_pkg: shared widths, register index type and debug FSM states for the GPR file.
package gpr_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  typedef logic [$clog2(NREG)-1:0] reg_idx_t;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} dbg_state_e;
endpackage

// File: rtl/gpr_dbg_ctrl.sv
// gpr_dbg_ctrl: debug request FSM (IDLE/EXEC/RESP) that yields to core writes.
module gpr_dbg_ctrl
  import gpr_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            dbg_req_valid,
  output logic            dbg_req_ready,
  input  logic            dbg_req_write,
  input  logic [4:0]      dbg_req_addr,
  input  logic [XLEN-1:0] dbg_req_wdata,
  output logic            dbg_resp_valid,
  input  logic            dbg_resp_ready,
  output logic [XLEN-1:0] dbg_resp_data,
  input  logic            wen,
  input  logic [XLEN-1:0] rd_data,
  output logic [4:0]      acc_addr,
  output logic            acc_we,
  output logic [XLEN-1:0] acc_wdata
);
  dbg_state_e      state_q, state_d;
  logic            write_q, write_d;
  logic [4:0]      addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d, resp_q, resp_d;

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    acc_we  = 1'b0;
    case (state_q)
      IDLE: if (dbg_req_valid) begin
        state_d = EXEC;
        write_d = dbg_req_write;
        addr_d  = dbg_req_addr;
        wdata_d = dbg_req_wdata;
      end
      // The core owns the write port; wait until it is idle, however long.
      EXEC: if (!wen) begin
        state_d = RESP;
        acc_we  = write_q && addr_q != '0;
        resp_d  = addr_q == '0 ? '0 : write_q ? wdata_q : rd_data;
      end
      RESP: if (dbg_resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
    end
  end

  assign dbg_req_ready  = state_q == IDLE;
  assign dbg_resp_valid = state_q == RESP;
  assign dbg_resp_data  = resp_q;
  assign acc_addr       = addr_q;
  assign acc_wdata      = wdata_q;
endmodule

// File: rtl/gpr_file.sv
// gpr_file: 32x64 register file, two bypassed read ports, one core write port, debug port.
// Define GPR_SIM_EXPORT_EN to expose the registered array on regs_flat.
module gpr_file
  import gpr_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [4:0]           rs1_addr,
  output logic [XLEN-1:0]      rs1_data,
  input  logic [4:0]           rs2_addr,
  output logic [XLEN-1:0]      rs2_data,
  input  logic                 wen,
  input  logic [4:0]           waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic                 dbg_req_valid,
  output logic                 dbg_req_ready,
  input  logic                 dbg_req_write,
  input  logic [4:0]           dbg_req_addr,
  input  logic [XLEN-1:0]      dbg_req_wdata,
  output logic                 dbg_resp_valid,
  input  logic                 dbg_resp_ready,
`ifdef GPR_SIM_EXPORT_EN
  output logic [XLEN-1:0]      dbg_resp_data,
  output logic [NREG*XLEN-1:0] regs_flat
`else
  output logic [XLEN-1:0]      dbg_resp_data
`endif
);
  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic [4:0]                acc_addr;
  logic                      acc_we;
  logic [XLEN-1:0]           acc_wdata;

  gpr_dbg_ctrl u_dbg (
    .clock          (clock),
    .reset          (reset),
    .dbg_req_valid  (dbg_req_valid),
    .dbg_req_ready  (dbg_req_ready),
    .dbg_req_write  (dbg_req_write),
    .dbg_req_addr   (dbg_req_addr),
    .dbg_req_wdata  (dbg_req_wdata),
    .dbg_resp_valid (dbg_resp_valid),
    .dbg_resp_ready (dbg_resp_ready),
    .dbg_resp_data  (dbg_resp_data),
    .wen            (wen),
    .rd_data        (regs_q[acc_addr]),
    .acc_addr       (acc_addr),
    .acc_we         (acc_we),
    .acc_wdata      (acc_wdata)
  );

  // Debug writes only happen when wen is low, so the two writers never collide.
  always_comb begin
    regs_d = regs_q;
    if (wen && waddr != '0) regs_d[waddr] = wdata;
    else if (acc_we) regs_d[acc_addr] = acc_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) regs_q <= '0;
    else regs_q <= regs_d;
  end

  always_comb begin
    rs1_data = rs1_addr == '0 ? '0 : (wen && waddr == rs1_addr) ? wdata : regs_q[rs1_addr];
    rs2_data = rs2_addr == '0 ? '0 : (wen && waddr == rs2_addr) ? wdata : regs_q[rs2_addr];
  end

`ifdef GPR_SIM_EXPORT_EN
  assign regs_flat = regs_q;
`endif
endmodule

// File: tb/tb_gpr_file.sv
// tb_gpr_file: directed and randomized checks of gpr_file against an array model.
module tb_gpr_file;
  logic         clock = 0, reset = 1;
  logic [4:0]   rs1_addr = 0, rs2_addr = 0, waddr = 0, dbg_req_addr = 0;
  logic [63:0]  rs1_data, rs2_data, wdata = 0, dbg_req_wdata = 0, dbg_resp_data;
  logic         wen = 0, dbg_req_valid = 0, dbg_req_ready, dbg_req_write = 0;
  logic         dbg_resp_valid, dbg_resp_ready = 0;
  logic [2047:0] regs_flat;
  logic [63:0]  model [32];
  int           errors = 0, checks = 0;

  gpr_file dut (
    .clock(clock), .reset(reset),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_write(dbg_req_write),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_resp_valid(dbg_resp_valid), .dbg_resp_ready(dbg_resp_ready),
`ifdef GPR_SIM_EXPORT_EN
    .regs_flat(regs_flat),
`endif
    .dbg_resp_data(dbg_resp_data)
  );
`ifndef GPR_SIM_EXPORT_EN
  assign regs_flat = '0;
`endif

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, committing what the model says the core write does.
  task automatic tick;
    if (wen && waddr != 0 && !reset) model[waddr] = wdata;
    @(posedge clock);
    #2;
  endtask

  function automatic logic [63:0] expect_rd(input logic [4:0] a);
    if (a == 0) return 0;
    if (wen && waddr == a) return wdata;
    return model[a];
  endfunction

  task automatic clear_model;
    for (int i = 0; i < 32; i++) model[i] = 0;
  endtask

  task automatic dbg_access(input logic w, input logic [4:0] a, input logic [63:0] d, input string tag);
    logic [63:0] exp;
    int lat;
    wen = 0;
    dbg_req_valid = 1; dbg_req_write = w; dbg_req_addr = a; dbg_req_wdata = d;
    #1 check({tag, "_ready"}, {63'b0, dbg_req_ready}, 64'd1);
    exp = w ? (a == 0 ? 64'd0 : d) : model[a];
    tick;
    dbg_req_valid = 0;
    lat = 1;
    while (!dbg_resp_valid && lat < 20) begin tick; lat++; end
    check({tag, "_lat"}, 64'(lat), 64'd2);
    check({tag, "_data"}, dbg_resp_data, exp);
    if (w && a != 0) model[a] = d;
    dbg_resp_ready = 1;
    tick;
    dbg_resp_ready = 0;
    check({tag, "_done"}, {63'b0, dbg_resp_valid}, 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    clear_model();
    rs1_addr = 5; rs2_addr = 31;
    #12;
    check("rst_rs1", rs1_data, 0);
    check("rst_rs2", rs2_data, 0);
    check("rst_ready", {63'b0, dbg_req_ready}, 1);
    check("rst_valid", {63'b0, dbg_resp_valid}, 0);
    check("rst_rdata", dbg_resp_data, 0);
    reset = 0;
    tick;
    wen = 1; waddr = 0; wdata = 64'hDEAD; rs1_addr = 0;
    #1 check("x0_bypass", rs1_data, 0);
    tick; wen = 0;
    #1 check("x0_read", rs1_data, 0);
    wen = 1; waddr = 7; wdata = 64'h1234; rs1_addr = 7;
    #1 check("bypass_same", rs1_data, 64'h1234);
    tick; wen = 0;
    #1 check("bypass_next", rs1_data, 64'h1234);
    dbg_access(1, 10, 64'hCAFE, "dbg_wr10");
    dbg_access(0, 10, 0, "dbg_rd10");
    rs2_addr = 10;
    #1 check("core_rd10", rs2_data, 64'hCAFE);
    dbg_access(1, 0, 64'hBEEF, "dbg_wr0");
    rs1_addr = 0;
    #1 check("x0_after_dbg", rs1_data, 0);
    // Core writes x3 for three cycles while the debug read waits in EXEC.
    dbg_req_valid = 1; dbg_req_write = 0; dbg_req_addr = 3;
    tick; dbg_req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      wen = 1; waddr = 3; wdata = 64'h33 + 64'(i) * 64'h11;
      #1 check("exec_hold_valid", {63'b0, dbg_resp_valid}, 0);
      check("exec_hold_ready", {63'b0, dbg_req_ready}, 0);
      tick;
    end
    wen = 0;
    #1 check("exec_after_wen", {63'b0, dbg_resp_valid}, 0);
    tick;
    check("exec_resp_valid", {63'b0, dbg_resp_valid}, 1);
    check("exec_resp_data", dbg_resp_data, 64'h55);
    dbg_resp_ready = 1; tick; dbg_resp_ready = 0;
    // Response must stay put while the consumer stalls, then reset drops it.
    dbg_req_valid = 1; dbg_req_write = 0; dbg_req_addr = 7;
    tick; dbg_req_valid = 0;
    tick;
    held = dbg_resp_data;
    check("stall_data0", held, 64'h1234);
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", {63'b0, dbg_resp_valid}, 1);
      check("stall_data", dbg_resp_data, 64'h1234);
      check("stall_ready", {63'b0, dbg_req_ready}, 0);
      tick;
    end
    reset = 1;
    #1 check("rst_resp_valid", {63'b0, dbg_resp_valid}, 0);
    check("rst_resp_ready", {63'b0, dbg_req_ready}, 1);
    check("rst_resp_data", dbg_resp_data, 0);
    clear_model();
    tick; reset = 0;
    rs1_addr = 7;
    #1 check("rst_cleared", rs1_data, 0);
    // Reset inside EXEC must abandon a pending debug write.
    dbg_req_valid = 1; dbg_req_write = 1; dbg_req_addr = 12; dbg_req_wdata = 64'h77;
    tick; dbg_req_valid = 0;
    reset = 1; #1 reset = 0;
    tick; tick;
    rs1_addr = 12;
    #1 check("exec_abandon", rs1_data, 0);
    check("exec_abandon_valid", {63'b0, dbg_resp_valid}, 0);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(7) == 0) begin
        dbg_access(1'($urandom_range(1)), $urandom_range(7) == 0 ? 5'd0 : 5'($urandom), {$urandom, $urandom}, "rnd_dbg");
      end else begin
        wen = 1'($urandom_range(1)); waddr = 5'($urandom); wdata = {$urandom, $urandom};
        rs1_addr = $urandom_range(3) == 0 ? waddr : 5'($urandom);
        rs2_addr = 5'($urandom);
        #1 check("rnd_rs1", rs1_data, expect_rd(rs1_addr));
        check("rnd_rs2", rs2_data, expect_rd(rs2_addr));
        tick;
      end
    end
    wen = 0;
`ifdef GPR_SIM_EXPORT_EN
    wen = 1; waddr = 31; wdata = 64'hFFFF_0000_0000_0001;
    #1 check("flat_no_bypass", regs_flat[2047:1984], model[31]);
    tick; wen = 0;
    check("flat_x31", regs_flat[2047:1984], 64'hFFFF_0000_0000_0001);
    check("flat_x0", regs_flat[63:0], 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gpr_file.md
GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 Parameters SHALL be none; widths SHALL come from package constants XLEN=64 and NREG=32.
REQ-002 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 rs1_addr  in  5  read port 1 index.
REQ-005 rs1_data  out  64  read port 1 data.
REQ-006 rs2_addr  in  5  read port 2 index.
REQ-007 rs2_data  out  64  read port 2 data.
REQ-008 wen  in  1  core write enable.
REQ-009 waddr  in  5  core write index.
REQ-010 wdata  in  64  core write data.
REQ-011 dbg_req_valid  in  1  debug request valid.
REQ-012 dbg_req_ready  out  1  debug request accepted.
REQ-013 dbg_req_write  in  1  1=write, 0=read.
REQ-014 dbg_req_addr  in  5  debug register index.
REQ-015 dbg_req_wdata  in  64  debug write data.
REQ-016 dbg_resp_valid  out  1  debug response valid.
REQ-017 dbg_resp_ready  in  1  debug response consumed.
REQ-018 dbg_resp_data  out  64  read data, or written value for writes.
REQ-019 regs_flat  out  2048  x0..x31 concatenated, x0 at bits [63:0]; present only under GPR_SIM_EXPORT_EN.

Function
REQ-020 x0 SHALL read as 0 on every port; writes to index 0 SHALL be discarded.
REQ-021 Reads SHALL be combinational with write-first bypass: if wen and waddr==rsN_addr!=0, rsN_data SHALL equal wdata in the same cycle.
REQ-022 A core write SHALL be visible in the array from the cycle after the edge where wen=1.
REQ-023 Debug FSM states SHALL be IDLE, EXEC and RESP.
REQ-024 IDLE: dbg_req_ready=1; on valid&ready, the request SHALL be captured and the FSM SHALL go to EXEC.
REQ-025 EXEC: if wen=1, SHALL hold (core has priority, no timeout); else SHALL perform the access in one cycle and go to RESP.
REQ-026 A debug read SHALL return the array value after any same-cycle core write has committed; a debug write SHALL update the array at the EXEC exit edge.
REQ-027 RESP: dbg_resp_valid=1 and dbg_resp_data stable until dbg_resp_ready=1, then the FSM SHALL go to IDLE; there SHALL be no RESP->IDLE->accept in the same cycle.
REQ-028 Minimum debug latency SHALL be 2 cycles from acceptance to dbg_resp_valid.
REQ-029 A debug access to x0 SHALL complete normally, with no write and dbg_resp_data=0.
REQ-030 dbg_req_ready SHALL be 0 in EXEC and RESP; requests SHALL NOT be queued.

Reset
REQ-031 Reset SHALL clear all 32 registers to 0 and force the FSM to IDLE, with dbg_resp_valid=0, dbg_resp_data=0 and dbg_req_ready=1 while reset is asserted.
REQ-032 Reset asserted mid-EXEC or mid-RESP SHALL abandon the request without writing the array.

Configuration
REQ-033 With GPR_SIM_EXPORT_EN defined, regs_flat SHALL present the registered array (no bypass), updated each cycle, for the simulation GPR-snapshot consumer.
REQ-034 Without GPR_SIM_EXPORT_EN, regs_flat SHALL be absent from the port list and functional behaviour SHALL be otherwise identical.

Structure
REQ-035 A shared package SHALL hold XLEN, NREG, the register-index typedef and the debug FSM state enum.
REQ-036 The debug FSM SHALL be a sub-module named gpr_dbg_ctrl; the array and bypass logic SHALL reside in gpr_file.

Verification
REQ-037 Reset, then read rs1=5, rs2=31 -> both 0; write x0=0xDEAD, then read x0 -> 0.
REQ-038 wen=1, waddr=7, wdata=0x1234 with rs1_addr=7 in the same cycle -> rs1_data=0x1234 that cycle; next cycle, with wen=0 -> 0x1234.
REQ-039 Debug write x10=0xCAFE, then debug read x10 -> resp 2 cycles after acceptance with data 0xCAFE; core read x10 -> 0xCAFE.
REQ-040 Debug read x3 accepted while wen=1 for 3 cycles (last write x3=0x55) -> FSM holds in EXEC 3 cycles, then resp=0x55.
REQ-041 Hold dbg_resp_ready=0 for 4 cycles in RESP -> valid and data stable, dbg_req_ready=0; reset during RESP -> IDLE, valid=0.
REQ-042 With GPR_SIM_EXPORT_EN: write x31=0xFFFF_0000_0000_0001 -> regs_flat[2047:1984] equals it on the next cycle.
